phase_marker_emitter: RTL
=========================

// Module: phase_marker_emitter
// PURPOSE
//  Encoder side of the phase-marker protocol. Turns phase events (phase id + start/end) into marker
//  hint instructions {imm12={phase,end}, rs1=x0, funct3=3'b010, rd=x0, opcode=7'h13}, e.g. 32'h00402013
//  for TEXE start. Streams them as 32-bit word writes into testcase memory for fuzz stimulus
//  construction. Enforces start/end pairing per phase and reports sticky protocol errors.
// PARAMETERS
//  FIFO_DEPTH  4         marker words buffered between encoder and memory port (power of 2, >=2)
//  ADDR_W      32        memory byte-address width
//  NUM_PHASES  7         legal phase ids 0..NUM_PHASES-1 (VCTM,DELAY,TEXE,LEAK,INIT,BIM,TRAIN)
// PORTS
//  clock       in   1       single clock, all state on posedge
//  reset       in   1       synchronous, active-high
//  base_addr   in   ADDR_W  word-aligned start address, sampled while reset or flush is high
//  flush       in   1       1-cycle: drop FIFO, clear open mask, reload address, clear errors
//  req_valid   in   1       phase event request
//  req_phase   in   4       phase id
//  req_end     in   1       0=start marker, 1=end marker
//  req_ready   out  1       request accepted when req_valid && req_ready
//  mem_valid   out  1       write request to memory
//  mem_addr    out  ADDR_W  byte address of word being written
//  mem_wdata   out  32      marker instruction word
//  mem_ready   in   1       memory accepts write when mem_valid && mem_ready
//  open_mask   out  NUM_PHASES  bit p set = phase p started and not yet ended
//  err_illegal out  1       sticky: phase id >= NUM_PHASES requested
//  err_pairing out  1       sticky: start of open phase, or end of closed phase
//  emitted     out  16      count of words accepted by memory, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: req_ready=0, mem_valid=0, mem_addr=base_addr, mem_wdata=0, open_mask=0, errors=0,
//    emitted=0, FIFO empty.
//  - FSM: IDLE (after reset/flush, 1 cycle) -> RUN. req_ready = (state==RUN) && FIFO not full && !flush.
//  - Accepted request is checked combinationally the same cycle:
//    - illegal id: set err_illegal, nothing enqueued, mask unchanged.
//    - start with open_mask[p]=1, or end with open_mask[p]=0: set err_pairing, nothing enqueued.
//    - otherwise: enqueue word, then set (start) or clear (end) open_mask[p] on the next edge.
//  - FIFO is show-ahead. mem_valid = FIFO not empty; mem_wdata = head word.
//    A request accepted at cycle N appears on mem_valid at N+1 when the FIFO was empty; no bypass.
//  - Simultaneous enqueue and dequeue while full is not allowed: req_ready=0 when full, even if
//    mem_ready=1 that cycle. Enqueue and dequeue together on a non-full, non-empty FIFO keeps
//    occupancy constant.
//  - On each mem handshake: pop FIFO, mem_addr += 4 (wraps modulo 2^ADDR_W), emitted += 1 (saturating).
//  - mem_valid/mem_addr/mem_wdata hold stable while mem_valid && !mem_ready.
//  - flush or reset mid-transfer: in-flight word is dropped and mem_valid=0 next cycle.
//    Memory must tolerate abandoned requests. Flush takes priority over a same-cycle request or
//    handshake, and neither takes effect.
// TESTING
//  - Reset, base_addr=0x80001000, TEXE start then end (mem_ready=1) -> writes 0x00402013@0x80001000,
//    0x00502013@0x80001004; emitted=2; open_mask=0.
//  - END of VCTM with mask clear -> err_pairing=1, no mem_valid.
//    A following VCTM start is still emitted as 0x00002013.
//  - req_phase=7 -> err_illegal=1, nothing written; flush -> both errors clear.
//  - mem_ready=0, send 5 legal events with FIFO_DEPTH=4 -> req_ready drops after 4; mem signals stable.
//    Release mem_ready -> 5 words in order at consecutive addresses.
//  - base_addr=0xFFFFFFFC, two events -> second write at 0x00000000.
//  - flush while mem_valid&&!mem_ready with 3 queued -> mem_valid=0 next cycle, open_mask=0,
//    mem_addr=base_addr.

Source files
------------

// File: rtl/phase_marker_emitter_if.sv
// Request and memory-write handshake bundle for the phase-marker emitter.
// The master side is the emitter: it accepts phase requests and drives memory writes.
interface phase_marker_emitter_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic [3:0]        req_phase;
  logic              req_end;
  logic              req_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    input  req_valid, req_phase, req_end, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_phase, req_end, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata
  );
endinterface

// File: rtl/phase_marker_emitter.sv
// Phase-marker encoder: turns phase start/end events into marker hint
// instructions, queues them in a small show-ahead FIFO and streams them as
// word writes to consecutive memory addresses. Tracks open phases and keeps
// sticky protocol error flags.
module phase_marker_emitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int NUM_PHASES = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  flush,
  phase_marker_emitter_if.master bus,
  output logic [NUM_PHASES-1:0] open_mask,
  output logic                  err_illegal,
  output logic                  err_pairing,
  output logic [15:0]           emitted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  state_reg, state_next;
  logic [31:0]             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]          count_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [NUM_PHASES-1:0]   open_mask_reg, open_mask_next;
  logic                    err_illegal_reg, err_pairing_reg;
  logic [15:0]             emitted_reg;

  logic                    fifo_full, fifo_empty;
  logic                    req_ready_next;
  logic                    accept, phase_legal, phase_open, pair_bad, enq, deq;
  logic [NUM_PHASES-1:0]   phase_hit;
  logic [31:0]             marker_word;

  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);

  // One-hot decode of the requested phase; out-of-range ids decode to zero.
  for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_dec
    assign phase_hit[gi] = (bus.req_phase == 4'(gi));
  end

  assign phase_legal = (32'(bus.req_phase) < 32'(NUM_PHASES));
  assign phase_open  = |(open_mask_reg & phase_hit);
  assign accept      = bus.req_valid && req_ready_next;
  // Starting an already-open phase or ending a closed one breaks pairing.
  assign pair_bad    = phase_legal && (bus.req_end ? !phase_open : phase_open);
  assign enq         = accept && phase_legal && !pair_bad;
  // Flush wins over a same-cycle handshake: the word is abandoned, not counted.
  assign deq         = !flush && !fifo_empty && bus.mem_ready;

  // ADDI-style hint: imm12={phase,end}, rs1=x0, funct3=010, rd=x0, opcode=0x13.
  assign marker_word = {7'b0, bus.req_phase, bus.req_end, 5'b0, 3'b010, 5'b0, 7'h13};

  // Next-state, request-ready and open-mask update.
  always_comb begin
    state_next     = state_reg;
    req_ready_next = 1'b0;
    open_mask_next = open_mask_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_RUN;
      ST_RUN:  req_ready_next = !fifo_full && !flush;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (enq && phase_hit[i]) open_mask_next[i] = !bus.req_end;
    end
  end

  // State, FIFO bookkeeping, address, counters and sticky errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      addr_reg        <= base_addr;
      open_mask_reg   <= '0;
      err_illegal_reg <= 1'b0;
      err_pairing_reg <= 1'b0;
      emitted_reg     <= '0;
    end else if (flush) begin
      state_reg       <= ST_IDLE;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      addr_reg        <= base_addr;
      open_mask_reg   <= '0;
      err_illegal_reg <= 1'b0;
      err_pairing_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      open_mask_reg <= open_mask_next;
      count_reg     <= count_reg + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        addr_reg   <= addr_reg + ADDR_W'(4);
        if (emitted_reg != 16'hFFFF) emitted_reg <= emitted_reg + 16'd1;
      end
      if (accept && !phase_legal) err_illegal_reg <= 1'b1;
      if (accept && pair_bad)     err_pairing_reg <= 1'b1;
    end
  end

  // Marker word storage; occupancy is tracked separately so no reset is needed.
  always_ff @(posedge clock) begin
    if (enq) fifo_mem[wr_ptr_reg] <= marker_word;
  end

  assign bus.req_ready = req_ready_next;
  assign bus.mem_valid = !fifo_empty;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_reg];
  assign open_mask     = open_mask_reg;
  assign err_illegal   = err_illegal_reg;
  assign err_pairing   = err_pairing_reg;
  assign emitted       = emitted_reg;

endmodule
